axi_slave_ram: RTL and testbench

Synthesizable AXI4 slave memory. It is the responder end of the memory bus that the core's instruction-fetch and data-access masters drive.
- Replaces the behavioural slave BFM in system-level builds.
- One instance for instruction memory, one for data memory.
- Single-port word RAM behind a small read/write arbiter. Supports INCR/FIXED bursts with backpressure on every channel.

---
 rtl/axi_ram_pkg.sv | 30 +++
 rtl/ram_1p.sv | 29 ++
 rtl/axi_slave_ram.sv | 195 +++++++++++++++++++
 tb/tb_axi_slave_ram.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_pkg.sv
// Shared constants and types for the AXI4 slave RAM (axi_slave_ram, ram_1p).
package axi_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RDATA
    } state_t;

    // One read beat waiting in the output skid buffer.
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    // WRAP and the reserved encoding 11 both walk forward like INCR.
    function automatic logic burst_advances(input logic [1:0] burst);
        return (burst == BURST_INCR) || (burst == BURST_WRAP) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/ram_1p.sv
// Synchronous single-port 32-bit word RAM with byte enables and a registered read port.
module ram_1p #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] ram_array [DEPTH];

    // NOTE: the storage array is deliberately never reset; a reset loop over every word would not map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (en) begin
            if (|we) begin
                for (int b = 0; b < 4; b++) begin
                    if (we[b]) ram_array[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= ram_array[addr];
            end
        end
    end

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 slave memory: single-port RAM behind a round-robin read/write arbiter.
// Define AXI_RAM_RANGE_CHECK_EN to flag beats beyond the RAM depth instead of wrapping.
module axi_slave_ram
    import axi_ram_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_OFFSET_WIDTH   = 28,
    parameter int C_MEM_WORDS      = 2048
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [C_OFFSET_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic [1:0]                    S_AXI_AWBURST,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_OFFSET_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    localparam int AW = $clog2(C_MEM_WORDS);
`ifdef AXI_RAM_RANGE_CHECK_EN
    localparam int IDX_W = C_OFFSET_WIDTH - 1;  // room for the unwrapped index
`else
    localparam int IDX_W = AW;
`endif

    state_t           state;
    logic             prio_read;
    logic [IDX_W-1:0] b_idx;
    logic [7:0]       b_len, b_beat;
    logic             b_adv, wr_err, rd_done;
    logic             rd_pending, rd_pend_last, rd_pend_oor;
    logic             sk_valid;
    rbeat_t           sk, rd_in;
    logic [3:0]       ram_we;
    logic [31:0]      ram_rdata;
    logic [1:0]       credits;
    logic             last_beat, beat_oor, wbeat_err, r_pop, rd_issue;
    logic             unused_addr;

    assign unused_addr = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

`ifdef AXI_RAM_RANGE_CHECK_EN
    assign beat_oor = (b_idx >= IDX_W'(C_MEM_WORDS));
`else
    assign beat_oor = 1'b0;
`endif

    assign last_beat = (b_beat == b_len);
    assign wbeat_err = (S_AXI_WLAST != last_beat) || beat_oor;
    assign r_pop     = S_AXI_RVALID && S_AXI_RREADY;

    // A read is issued only if the skid buffer can absorb it one cycle later.
    assign credits  = {1'b0, S_AXI_RVALID} + {1'b0, sk_valid} + {1'b0, rd_pending};
    assign rd_issue = (state == ST_RDATA) && !rd_done
                   && ((credits < 2'd2) || (credits == 2'd2 && r_pop));

    assign ram_we = (state == ST_WDATA && S_AXI_WVALID && S_AXI_WREADY && !beat_oor)
                  ? S_AXI_WSTRB : 4'b0000;

    assign rd_in = '{data: rd_pend_oor ? 32'd0 : ram_rdata,
                     resp: rd_pend_oor ? RESP_SLVERR : RESP_OKAY,
                     last: rd_pend_last};

    ram_1p #(.DEPTH(C_MEM_WORDS), .AW(AW)) u_ram (
        .clk   (CLK),
        .en    (rd_issue || (|ram_we)),
        .we    (ram_we),
        .addr  (b_idx[AW-1:0]),
        .wdata (S_AXI_WDATA),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_IDLE;
            prio_read     <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RLAST   <= 1'b0;
            sk_valid      <= 1'b0;
            rd_pending    <= 1'b0;
            rd_done       <= 1'b0;
            wr_err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    S_AXI_AWREADY <= 1'b0;
                    S_AXI_ARREADY <= 1'b0;
                    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                        b_idx        <= IDX_W'(S_AXI_AWADDR[C_OFFSET_WIDTH-1:2]);
                        b_len        <= S_AXI_AWLEN;
                        b_adv        <= burst_advances(S_AXI_AWBURST);
                        b_beat       <= 8'd0;
                        wr_err       <= 1'b0;
                        S_AXI_WREADY <= 1'b1;
                        state        <= ST_WDATA;
                    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                        b_idx   <= IDX_W'(S_AXI_ARADDR[C_OFFSET_WIDTH-1:2]);
                        b_len   <= S_AXI_ARLEN;
                        b_adv   <= burst_advances(S_AXI_ARBURST);
                        b_beat  <= 8'd0;
                        rd_done <= 1'b0;
                        state   <= ST_RDATA;
                    end else if (!S_AXI_AWREADY && !S_AXI_ARREADY) begin
                        if (S_AXI_AWVALID && (!S_AXI_ARVALID || !prio_read)) begin
                            S_AXI_AWREADY <= 1'b1;
                            if (S_AXI_ARVALID) prio_read <= 1'b1;
                        end else if (S_AXI_ARVALID) begin
                            S_AXI_ARREADY <= 1'b1;
                            if (S_AXI_AWVALID) prio_read <= 1'b0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (S_AXI_WVALID && S_AXI_WREADY) begin
                        b_beat <= b_beat + 8'd1;
                        if (b_adv) b_idx <= b_idx + IDX_W'(1);
                        if (last_beat) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= (wr_err || wbeat_err) ? RESP_SLVERR : RESP_OKAY;
                            state        <= ST_WRESP;
                        end else begin
                            wr_err <= wr_err || wbeat_err;
                        end
                    end
                end
                ST_WRESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        S_AXI_BRESP  <= RESP_OKAY;
                        state        <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    rd_pending <= rd_issue;
                    if (rd_issue) begin
                        rd_pend_last <= last_beat;
                        rd_pend_oor  <= beat_oor;
                        b_beat       <= b_beat + 8'd1;
                        if (b_adv) b_idx <= b_idx + IDX_W'(1);
                        if (last_beat) rd_done <= 1'b1;
                    end
                    // Output register is the skid buffer head; the spare entry catches data landing during a stall.
                    if (!S_AXI_RVALID || r_pop) begin
                        if (sk_valid) begin
                            S_AXI_RDATA <= sk.data;
                            S_AXI_RRESP <= sk.resp;
                            S_AXI_RLAST <= sk.last;
                            sk_valid    <= rd_pending;
                            sk          <= rd_in;
                        end else begin
                            S_AXI_RVALID <= rd_pending;
                            S_AXI_RLAST  <= rd_pending && rd_pend_last;
                            if (rd_pending) begin
                                S_AXI_RDATA <= rd_in.data;
                                S_AXI_RRESP <= rd_in.resp;
                            end
                        end
                    end else if (rd_pending) begin
                        sk_valid <= 1'b1;
                        sk       <= rd_in;
                    end
                    if (r_pop && S_AXI_RLAST) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed self-checking bench for axi_slave_ram (default build, range check disabled).
module tb_axi_slave_ram;
    import axi_ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] wd [0:15];
    logic [3:0]  ws [0:15];
    logic [1:0]  got_bresp;
    logic [31:0] got_data [0:15];
    logic        got_last [0:15];
    logic [1:0]  got_resp [0:15];
    int          got_cyc  [0:15];
    int          got_n;

    always #5 clk = ~clk;

    axi_slave_ram dut (
        .CLK(clk), .RST(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWBURST(awburst),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARBURST(arburst),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wlast = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic ar_send(input logic [27:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int cyc = 0;
        araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        while (!arready && cyc < 20) begin tick(); cyc++; end
        check("arready", arready, 1);
        tick();
        arvalid = 1'b0;
    endtask

    // Collects n beats; cyc 0 is the sample right after the AR handshake edge.
    task automatic recv(input int n, input bit toggle);
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] held_d = '0;
        logic        held_l = 1'b0;
        got_n = 0;
        while (got_n < n && cyc < 100) begin
            if (stalled) check("stall_hold", {rvalid, rlast, rdata}, {1'b1, held_l, held_d});
            rready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (rvalid && rready) begin
                got_data[got_n] = rdata;
                got_last[got_n] = rlast;
                got_resp[got_n] = rresp;
                got_cyc[got_n]  = cyc;
                got_n++;
                stalled = 1'b0;
            end else begin
                stalled = rvalid;
                held_d  = rdata;
                held_l  = rlast;
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
        check("beat_count", got_n, n);
    endtask

    task automatic wr_burst(input logic [27:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input int n_beats, input int last_at);
        int cyc = 0;
        awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        while (!awready && cyc < 20) begin tick(); cyc++; end
        check("awready", awready, 1);
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < n_beats; i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at);
            cyc = 0;
            while (!wready && cyc < 20) begin tick(); cyc++; end
            check("wready", wready, 1);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("wready_low_after_burst", wready, 0);
        bready = 1'b1;
        cyc = 0;
        while (!bvalid && cyc < 20) begin tick(); cyc++; end
        check("bvalid", bvalid, 1);
        got_bresp = bresp;
        tick();
        bready = 1'b0;
        check("bvalid_cleared", bvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        awaddr = '0; awlen = '0; awburst = BURST_INCR; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arburst = BURST_INCR; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < 5; i++) dut.u_ram.ram_array[i] = 32'(i + 1);
        dut.u_ram.ram_array[5] = 32'h0;
        for (int i = 0; i < 8; i++) dut.u_ram.ram_array[16 + i] = 32'hC0DE_0010 + 32'(i);
        dut.u_ram.ram_array[2047] = 32'hFEED_F00D;

        // Reset values
        do_reset();
        check("rst_ready", {awready, wready, arready}, 3'b000);
        check("rst_valid", {bvalid, rvalid, rlast}, 3'b000);
        check("rst_rdata", rdata, 32'h0);
        check("rst_resp", {bresp, rresp}, 4'b0000);
        check("rst_state", dut.state, ST_IDLE);

        // INCR read of 5 words, RREADY held high
        rready = 1'b1;
        ar_send(28'h0, 8'd4, BURST_INCR);
        recv(5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("rd5_data", got_data[i], 32'(i + 1));
            check("rd5_last", got_last[i], (i == 4));
            check("rd5_resp", got_resp[i], RESP_OKAY);
            check("rd5_cycle", got_cyc[i], 2 + i);
        end
        check("rd5_idle", dut.state, ST_IDLE);

        // Two-beat write with partial strobe on the second beat
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'b1111;
        wd[1] = 32'h1122_3344; ws[1] = 4'b0011;
        wr_burst(28'h10, 8'd1, BURST_INCR, 2, 1);
        check("wr2_bresp", got_bresp, RESP_OKAY);
        check("wr2_word4", dut.u_ram.ram_array[4], 32'hAABB_CCDD);
        check("wr2_word5", dut.u_ram.ram_array[5], 32'h0000_3344);

        // WLAST early on beat 1 of a 4-beat burst
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h100 + 32'(i); ws[i] = 4'b1111; end
        wr_burst(28'h200, 8'd3, BURST_INCR, 4, 1);
        check("wlast_err_bresp", got_bresp, RESP_SLVERR);
        check("wlast_err_word128", dut.u_ram.ram_array[128], 32'h100);
        check("wlast_err_word131", dut.u_ram.ram_array[131], 32'h103);

        // FIXED write: every beat lands on the same word
        for (int i = 0; i < 3; i++) begin wd[i] = 32'h0A + 32'(i); ws[i] = 4'b1111; end
        wr_burst(28'h300, 8'd2, BURST_FIXED, 3, 2);
        check("fixed_wr_bresp", got_bresp, RESP_OKAY);
        check("fixed_wr_word192", dut.u_ram.ram_array[192], 32'h0C);

        // FIXED read repeats word 2
        ar_send(28'h8, 8'd2, BURST_FIXED);
        recv(3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("fixed_rd_data", got_data[i], 32'd3);
            check("fixed_rd_last", got_last[i], (i == 2));
        end

        // Address wraps from the top word to word 0 (encoding 11 behaves like INCR)
        ar_send(28'h1FFC, 8'd1, 2'b11);
        recv(2, 1'b0);
        check("wrap_rd_top", got_data[0], 32'hFEED_F00D);
        check("wrap_rd_zero", got_data[1], 32'h1);
        check("wrap_rd_last", {got_last[0], got_last[1]}, 2'b01);

        // Simultaneous AW/AR from reset: write first, then read
        do_reset();
        awaddr = 28'h100; awlen = 8'd0; awburst = BURST_INCR;
        araddr = 28'h0;   arlen = 8'd0; arburst = BURST_INCR;
        awvalid = 1'b1; arvalid = 1'b1;
        tick();
        check("arb1_grant_write", {awready, arready}, 2'b10);
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'h5A5A_5A5A; wstrb = 4'b1111; wlast = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        check("arb1_bvalid", {bvalid, bresp}, 3'b100);
        bready = 1'b1; awvalid = 1'b1;
        tick();
        bready = 1'b0;
        check("arb1_state_idle", dut.state, ST_IDLE);
        tick();
        check("arb2_grant_read", {awready, arready}, 2'b01);
        tick();
        arvalid = 1'b0;
        recv(1, 1'b0);
        check("arb2_rdata", got_data[0], 32'h1);
        check("arb2_rlast", got_last[0], 1'b1);
        check("arb1_word64", dut.u_ram.ram_array[64], 32'h5A5A_5A5A);
        do_reset();

        // 8-beat read with RREADY toggling each cycle
        ar_send(28'h40, 8'd7, BURST_INCR);
        recv(8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("toggle_data", got_data[i], 32'hC0DE_0010 + 32'(i));
            check("toggle_last", got_last[i], (i == 7));
        end
        check("toggle_idle", dut.state, ST_IDLE);

        // Reset in the middle of an 8-beat read, then a fresh read
        ar_send(28'h40, 8'd7, BURST_INCR);
        recv(3, 1'b0);
        check("mid_beat2", got_data[2], 32'hC0DE_0012);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rvalid", {rvalid, rlast}, 2'b00);
        check("mid_rst_state", dut.state, ST_IDLE);
        tick();
        check("mid_rst_quiet", rvalid, 1'b0);
        ar_send(28'h0, 8'd1, BURST_INCR);
        recv(2, 1'b0);
        check("post_rst_data0", got_data[0], 32'h1);
        check("post_rst_data1", got_data[1], 32'h2);
        check("post_rst_last", {got_last[0], got_last[1]}, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
